// File: rtl/trap_ctrl.sv
// Commit-side trap/return controller: turns a retiring exception into a one-cycle
// CSR write pulse, then flushes and redirects fetch to mtvec (or to mepc on mret).
module trap_ctrl #(
  parameter int DATA_LEN = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                inst_valid,
  input  logic [DATA_LEN-1:0] inst_PC,
  input  logic                is_illegal,
  input  logic                is_ecall,
  input  logic                is_ebreak,
  input  logic                is_mret,
  input  logic [DATA_LEN-1:0] mtvec,
  input  logic [DATA_LEN-1:0] mepc,
  output logic                unusual_flag,
  output logic [DATA_LEN-1:0] cause,
  output logic [DATA_LEN-1:0] trap_PC,
  output logic                flush,
  output logic                busy,
  output logic                redirect_valid,
  input  logic                redirect_ready,
  output logic [DATA_LEN-1:0] redirect_pc,
  output logic [31:0]         trap_cnt
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    TRAP     = 2'd1,
    REDIRECT = 2'd2
  } state_e;

  localparam logic [DATA_LEN-1:0] CAUSE_ILLEGAL = DATA_LEN'(2);
  localparam logic [DATA_LEN-1:0] CAUSE_EBREAK  = DATA_LEN'(3);
  localparam logic [DATA_LEN-1:0] CAUSE_ECALL   = DATA_LEN'(11);
  // Direct-mode only: the two low bits of mtvec/mepc never reach fetch.
  localparam logic [DATA_LEN-1:0] ALIGN_MASK    = {{(DATA_LEN-2){1'b1}}, 2'b00};

  state_e                state_q;
  logic                  unusual_flag_q;
  logic [DATA_LEN-1:0]   cause_q;
  logic [DATA_LEN-1:0]   trap_pc_q;
  logic                  busy_q;
  logic                  redirect_valid_q;
  logic [DATA_LEN-1:0]   redirect_pc_q;
  logic [31:0]           trap_cnt_q;

  logic                  trap_evt;
  logic                  mret_evt;
  logic [DATA_LEN-1:0]   cause_d;

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    cause_d  = CAUSE_EBREAK;
    trap_evt = inst_valid & (is_illegal | is_ecall | is_ebreak);
    mret_evt = inst_valid & is_mret & ~trap_evt;
    if (is_illegal)    cause_d = CAUSE_ILLEGAL;
    else if (is_ecall) cause_d = CAUSE_ECALL;
  end

  // NOTE: state uses non-blocking assignments; reset is synchronous and clears every output register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      unusual_flag_q   <= 1'b0;
      cause_q          <= '0;
      trap_pc_q        <= '0;
      busy_q           <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      trap_cnt_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (trap_evt) begin
            state_q        <= TRAP;
            unusual_flag_q <= 1'b1;
            cause_q        <= cause_d;
            trap_pc_q      <= inst_PC;
            redirect_pc_q  <= mtvec & ALIGN_MASK;
            busy_q         <= 1'b1;
          end else if (mret_evt) begin
            state_q          <= REDIRECT;
            redirect_pc_q    <= mepc & ALIGN_MASK;
            redirect_valid_q <= 1'b1;
            busy_q           <= 1'b1;
          end
        end
        TRAP: begin
          // cause/trap_PC are only meaningful alongside the pulse, so clear them here.
          state_q          <= REDIRECT;
          unusual_flag_q   <= 1'b0;
          cause_q          <= '0;
          trap_pc_q        <= '0;
          redirect_valid_q <= 1'b1;
          trap_cnt_q       <= trap_cnt_q + 32'd1;
        end
        REDIRECT: begin
          if (redirect_ready) begin
            state_q          <= IDLE;
            redirect_valid_q <= 1'b0;
            busy_q           <= 1'b0;
          end
        end
        default: begin
          state_q          <= IDLE;
          unusual_flag_q   <= 1'b0;
          cause_q          <= '0;
          trap_pc_q        <= '0;
          redirect_valid_q <= 1'b0;
          busy_q           <= 1'b0;
        end
      endcase
    end
  end

  assign unusual_flag   = unusual_flag_q;
  assign cause          = cause_q;
  assign trap_PC        = trap_pc_q;
  assign busy           = busy_q;
  assign flush          = busy_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign trap_cnt       = trap_cnt_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: expected CSR pulses and redirects are queued at issue
// and a negedge monitor pops them whenever the DUT presents one.
module tb_trap_ctrl;

  typedef struct {
    logic [31:0] cause;
    logic [31:0] pc;
  } trap_exp_t;

  logic        clk;
  logic        rst_n;
  logic        inst_valid;
  logic [31:0] inst_PC;
  logic        is_illegal, is_ecall, is_ebreak, is_mret;
  logic [31:0] mtvec, mepc;
  logic        unusual_flag;
  logic [31:0] cause, trap_PC;
  logic        flush, busy, redirect_valid, redirect_ready;
  logic [31:0] redirect_pc, trap_cnt;

  logic [63:0] inst_pc64, mtvec64, mepc64;
  logic        unusual_flag64, flush64, busy64, redirect_valid64;
  logic [63:0] cause64, trap_pc64, redirect_pc64;
  logic [31:0] trap_cnt64;

  int          checks;
  int          failures;
  logic        mon_en;
  trap_exp_t   trap_q[$];
  logic [31:0] redir_q[$];
  trap_exp_t   mon_e;
  logic [31:0] mon_pc;

  trap_ctrl #(.DATA_LEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .inst_valid(inst_valid), .inst_PC(inst_PC),
    .is_illegal(is_illegal), .is_ecall(is_ecall), .is_ebreak(is_ebreak), .is_mret(is_mret),
    .mtvec(mtvec), .mepc(mepc), .unusual_flag(unusual_flag), .cause(cause), .trap_PC(trap_PC),
    .flush(flush), .busy(busy), .redirect_valid(redirect_valid), .redirect_ready(redirect_ready),
    .redirect_pc(redirect_pc), .trap_cnt(trap_cnt)
  );

  trap_ctrl #(.DATA_LEN(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .inst_valid(inst_valid), .inst_PC(inst_pc64),
    .is_illegal(is_illegal), .is_ecall(is_ecall), .is_ebreak(is_ebreak), .is_mret(is_mret),
    .mtvec(mtvec64), .mepc(mepc64), .unusual_flag(unusual_flag64), .cause(cause64),
    .trap_PC(trap_pc64), .flush(flush64), .busy(busy64), .redirect_valid(redirect_valid64),
    .redirect_ready(redirect_ready), .redirect_pc(redirect_pc64), .trap_cnt(trap_cnt64)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inst();
    inst_valid = 1'b0;
    is_illegal = 1'b0;
    is_ecall   = 1'b0;
    is_ebreak  = 1'b0;
    is_mret    = 1'b0;
  endtask

  // Monitor: compare every CSR pulse and every completed redirect handshake.
  always @(negedge clk) begin
    if (mon_en) begin
      if (unusual_flag) begin
        if (trap_q.size() == 0) begin
          check("trap_unexpected", {63'd0, unusual_flag}, 64'd0);
        end else begin
          mon_e = trap_q.pop_front();
          check("trap_cause", {32'd0, cause}, {32'd0, mon_e.cause});
          check("trap_pc", {32'd0, trap_PC}, {32'd0, mon_e.pc});
        end
      end else begin
        check("cause_pc_zero_idle", {cause, trap_PC}, 64'd0);
      end
      if (redirect_valid && redirect_ready) begin
        if (redir_q.size() == 0) begin
          check("redirect_unexpected", {63'd0, redirect_valid}, 64'd0);
        end else begin
          mon_pc = redir_q.pop_front();
          check("redirect_pc", {32'd0, redirect_pc}, {32'd0, mon_pc});
        end
      end
    end
  end

  initial begin
    checks   = 0;
    failures = 0;
    mon_en   = 1'b0;
    rst_n    = 1'b0;
    clear_inst();
    inst_PC        = '0;
    mtvec          = '0;
    mepc           = '0;
    inst_pc64      = '0;
    mtvec64        = '0;
    mepc64         = '0;
    redirect_ready = 1'b0;
    repeat (2) tick();

    check("rst_unusual_flag", {63'd0, unusual_flag}, 64'd0);
    check("rst_cause_pc", {cause, trap_PC}, 64'd0);
    check("rst_busy_flush", {62'd0, busy, flush}, 64'd0);
    check("rst_redirect", {31'd0, redirect_valid, redirect_pc}, 64'd0);
    check("rst_trap_cnt", {32'd0, trap_cnt}, 64'd0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    tick();

    // ecall: pulse at T+1, redirect at T+2, idle at T+3
    inst_valid = 1'b1; is_ecall = 1'b1;
    inst_PC = 32'h8000_0010; mtvec = 32'h8000_0104; redirect_ready = 1'b1;
    trap_q.push_back('{cause: 32'd11, pc: 32'h8000_0010});
    redir_q.push_back(32'h8000_0104);
    tick(); clear_inst();
    check("ecall_t1_flag", {63'd0, unusual_flag}, 64'd1);
    check("ecall_t1_busy_flush", {62'd0, busy, flush}, 64'd3);
    check("ecall_t1_no_redirect", {63'd0, redirect_valid}, 64'd0);
    tick();
    check("ecall_t2_redirect_valid", {63'd0, redirect_valid}, 64'd1);
    check("ecall_t2_redirect_pc", {32'd0, redirect_pc}, 64'h8000_0104);
    tick();
    check("ecall_t3_busy", {63'd0, busy}, 64'd0);
    check("ecall_t3_trap_cnt", {32'd0, trap_cnt}, 64'd1);

    // mret: no CSR pulse, redirect to aligned mepc at T+1
    inst_valid = 1'b1; is_mret = 1'b1; mepc = 32'h8000_0013;
    redir_q.push_back(32'h8000_0010);
    tick(); clear_inst();
    check("mret_t1_redirect_valid", {63'd0, redirect_valid}, 64'd1);
    check("mret_t1_redirect_pc", {32'd0, redirect_pc}, 64'h8000_0010);
    check("mret_t1_no_flag", {63'd0, unusual_flag}, 64'd0);
    tick();
    check("mret_t2_busy", {63'd0, busy}, 64'd0);
    check("mret_trap_cnt", {32'd0, trap_cnt}, 64'd1);

    // illegal+ecall+mret together, accepted right after returning to IDLE
    inst_valid = 1'b1; is_illegal = 1'b1; is_ecall = 1'b1; is_mret = 1'b1;
    inst_PC = 32'h8000_0020; mtvec = 32'h8000_0200; mepc = 32'h8000_0400;
    trap_q.push_back('{cause: 32'd2, pc: 32'h8000_0020});
    redir_q.push_back(32'h8000_0200);
    tick(); clear_inst();
    check("prio_flag", {63'd0, unusual_flag}, 64'd1);
    tick();
    check("prio_redirect_pc", {32'd0, redirect_pc}, 64'h8000_0200);
    tick();
    check("prio_trap_cnt", {32'd0, trap_cnt}, 64'd2);

    // ebreak with 5 cycles of backpressure; ecall during the wait is dropped
    redirect_ready = 1'b0;
    inst_valid = 1'b1; is_ebreak = 1'b1;
    inst_PC = 32'h8000_0030; mtvec = 32'h8000_0303;
    trap_q.push_back('{cause: 32'd3, pc: 32'h8000_0030});
    redir_q.push_back(32'h8000_0300);
    tick(); clear_inst();
    mtvec = 32'h9000_0000;
    inst_valid = 1'b1; is_ecall = 1'b1; inst_PC = 32'h8000_0040;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_valid_flush", {62'd0, redirect_valid, flush}, 64'd3);
      check("bp_hold_pc", {32'd0, redirect_pc}, 64'h8000_0300);
      tick();
    end
    clear_inst();
    redirect_ready = 1'b1;
    tick();
    check("bp_done_busy", {63'd0, busy}, 64'd0);
    check("bp_trap_cnt", {32'd0, trap_cnt}, 64'd3);
    tick();
    check("bp_ecall_dropped", {62'd0, busy, unusual_flag}, 64'd0);

    // reset while waiting in REDIRECT abandons the redirect
    redirect_ready = 1'b0;
    inst_valid = 1'b1; is_ecall = 1'b1;
    inst_PC = 32'h8000_0050; mtvec = 32'h8000_0500;
    trap_q.push_back('{cause: 32'd11, pc: 32'h8000_0050});
    tick(); clear_inst();
    tick();
    check("rstmid_in_redirect", {63'd0, redirect_valid}, 64'd1);
    rst_n = 1'b0;
    tick();
    check("rstmid_redirect_valid", {63'd0, redirect_valid}, 64'd0);
    check("rstmid_busy", {62'd0, busy, flush}, 64'd0);
    check("rstmid_trap_cnt", {32'd0, trap_cnt}, 64'd0);
    check("rstmid_redirect_pc", {32'd0, redirect_pc}, 64'd0);
    rst_n = 1'b1;
    redirect_ready = 1'b1;
    tick();

    // 64-bit datapath: zero-extended cause and full-width PCs
    inst_valid = 1'b1; is_ecall = 1'b1;
    inst_PC = 32'h8000_0060; mtvec = 32'h8000_0600;
    inst_pc64 = 64'hFFFF_0000_8000_0060; mtvec64 = 64'h0000_0001_0000_0106;
    trap_q.push_back('{cause: 32'd11, pc: 32'h8000_0060});
    redir_q.push_back(32'h8000_0600);
    tick(); clear_inst();
    check("w64_flag", {63'd0, unusual_flag64}, 64'd1);
    check("w64_cause", cause64, 64'h0000_0000_0000_000B);
    check("w64_trap_pc", trap_pc64, 64'hFFFF_0000_8000_0060);
    tick();
    check("w64_redirect_valid", {63'd0, redirect_valid64}, 64'd1);
    check("w64_redirect_pc", redirect_pc64, 64'h0000_0001_0000_0104);
    tick();
    check("w64_cause_cleared", cause64, 64'd0);
    check("w64_trap_cnt", {32'd0, trap_cnt64}, 64'd1);
    check("w32_trap_cnt", {32'd0, trap_cnt}, 64'd1);

    tick();
    mon_en = 1'b0;
    check("trap_q_drained", 64'(trap_q.size()), 64'd0);
    check("redir_q_drained", 64'(redir_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
